// File: rtl/systolic_ctrl_pkg_30.sv
// systolic_ctrl_pkg_30
//   Shared definitions for the 4x4 systolic tile sequencer:
//   - state_e     : sequencer states (LOAD, CLEAR, RUN, UNLOAD)
//   - BEAT_*      : load-stream beat numbers (A rows on beats 0-3, B rows on beats 4-7)
//   - elem_lsb()  : LSB of element [r][c] in a flat 4x4 operand/result bus
package systolic_ctrl_pkg_30;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

  localparam logic [2:0] BEAT_A0   = 3'd0;  // first A row beat
  localparam logic [2:0] BEAT_B0   = 3'd4;  // first B row beat
  localparam logic [2:0] BEAT_LAST = 3'd7;  // last beat of a tile pair

  // Element [r][c] of a 4x4 tile of n-bit words sits at bits [(4r+c)*n +: n].
  function automatic int elem_lsb(input int r, input int c, input int n);
    return (4 * r + c) * n;
  endfunction

endpackage

// File: rtl/systolic_tile_buf_30.sv
// systolic_tile_buf_30
//   Operand and result storage for one systolic job.
//   Ports:
//     clk_30, reset_30        clock, asynchronous active-high reset
//     wr_en_i                 write one tile row from the load stream
//     wr_beat_i               beat number 0-7 (0-3 -> A rows, 4-7 -> B rows)
//     wr_data_i  [4N]         row data, lane c -> column c
//     cap_en_i                capture the full 4x4 result tile
//     cap_data_i [16N]        result tile from the array
//     rd_row_i   [2]          result row to present
//     a_o, b_o   [16N]        held A/B operands driven to the array
//     rd_data_o  [4N]         selected result row
module systolic_tile_buf_30
  import systolic_ctrl_pkg_30::*;
#(
  parameter int N = 16
) (
  input  logic            clk_30,
  input  logic            reset_30,
  input  logic            wr_en_i,
  input  logic [2:0]      wr_beat_i,
  input  logic [4*N-1:0]  wr_data_i,
  input  logic            cap_en_i,
  input  logic [16*N-1:0] cap_data_i,
  input  logic [1:0]      rd_row_i,
  output logic [16*N-1:0] a_o,
  output logic [16*N-1:0] b_o,
  output logic [4*N-1:0]  rd_data_o
);

  logic [16*N-1:0] a_q;
  logic [16*N-1:0] b_q;
  logic [16*N-1:0] z_q;
  logic [1:0]      wr_row;

  // Four rows per tile, so the low two beat bits give the row in either tile.
  assign wr_row = wr_beat_i[1:0];

  // NOTE: storage is reset because the array sees arr_a/arr_b directly and
  // the result bus must read as zero before the first capture.
  always_ff @(posedge clk_30 or posedge reset_30) begin
    if (reset_30) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
    end else begin
      if (wr_en_i) begin
        for (int c = 0; c < 4; c++) begin
          if (wr_beat_i >= BEAT_B0) begin
            b_q[elem_lsb(int'(wr_row), c, N) +: N] <= wr_data_i[c*N +: N];
          end else begin
            a_q[elem_lsb(int'(wr_row), c, N) +: N] <= wr_data_i[c*N +: N];
          end
        end
      end
      if (cap_en_i) begin
        z_q <= cap_data_i;
      end
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  // Row r occupies the contiguous slice starting at element [r][0].
  assign rd_data_o = z_q[elem_lsb(int'(rd_row_i), 0, N) +: 4*N];

endmodule

// File: rtl/systolic_tile_ctrl_30.sv
// systolic_tile_ctrl_30
//   Job sequencer for the 4x4 floating-point systolic MAC array: loads an
//   A and B tile from an 8-beat stream, pulses the array clear, waits for
//   the array result (ignoring stale valid for MIN_WAIT cycles, aborting
//   after TIMEOUT cycles) and returns the 16 results as 4 row beats.
//   Ports:
//     clk_30, reset_30                  clock, asynchronous active-high reset
//     in_valid/in_ready/in_data         load stream (4N per beat)
//     arr_a, arr_b                      operand buses to the array (16N each)
//     arr_clr                           one-cycle clear pulse per job
//     arr_z, arr_valid                  array results and result valid
//     out_valid/out_ready/out_data      result row stream (4N per beat)
//     out_row, out_last                 row index of out_data, last-row flag
//     busy                              job in progress
//     err_timeout                       sticky abort flag
//     jobs_done                         wrapping completed-job counter
module systolic_tile_ctrl_30
  import systolic_ctrl_pkg_30::*;
#(
  parameter int N        = 16,
  parameter int MIN_WAIT = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic            clk_30,
  input  logic            reset_30,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*N-1:0]  in_data,
  output logic [16*N-1:0] arr_a,
  output logic [16*N-1:0] arr_b,
  output logic            arr_clr,
  input  logic [16*N-1:0] arr_z,
  input  logic            arr_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*N-1:0]  out_data,
  output logic [1:0]      out_row,
  output logic            out_last,
  output logic            busy,
  output logic            err_timeout,
  output logic [7:0]      jobs_done
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WW = $clog2(TIMEOUT);

  state_e        state_q, state_d;
  logic [2:0]    beat_q,  beat_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [1:0]    row_q,   row_d;
  logic          err_q,   err_d;
  logic [7:0]    jobs_q,  jobs_d;
  logic          load_en;
  logic          cap_en;

  always_ff @(posedge clk_30 or posedge reset_30) begin
    if (reset_30) begin
      state_q <= ST_LOAD;
      beat_q  <= '0;
      wait_q  <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      err_q   <= err_d;
      jobs_q  <= jobs_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    row_d   = row_q;
    err_d   = err_q;
    jobs_d  = jobs_q;
    load_en = 1'b0;
    cap_en  = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          load_en = 1'b1;
          beat_d  = beat_q + 3'd1;
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = ST_CLEAR;
          end
        end
      end

      ST_CLEAR: begin
        wait_d  = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        wait_d = wait_q + WW'(1);
        // The first MIN_WAIT cycles may still show valid from the previous job.
        if (arr_valid && (wait_q >= WW'(MIN_WAIT))) begin
          cap_en  = 1'b1;
          row_d   = '0;
          state_d = ST_UNLOAD;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          beat_d  = '0;
          state_d = ST_LOAD;
        end
      end

      ST_UNLOAD: begin
        if (out_ready) begin
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            jobs_d  = jobs_q + 8'd1;
            beat_d  = '0;
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  systolic_tile_buf_30 #(
    .N (N)
  ) u_buf (
    .clk_30     (clk_30),
    .reset_30   (reset_30),
    .wr_en_i    (load_en),
    .wr_beat_i  (beat_q),
    .wr_data_i  (in_data),
    .cap_en_i   (cap_en),
    .cap_data_i (arr_z),
    .rd_row_i   (row_q),
    .a_o        (arr_a),
    .b_o        (arr_b),
    .rd_data_o  (out_data)
  );

  // All outputs decode registered state only.
  assign in_ready    = (state_q == ST_LOAD);
  assign arr_clr     = (state_q == ST_CLEAR);
  assign out_valid   = (state_q == ST_UNLOAD);
  assign out_row     = row_q;
  // row_q returns to 0 whenever UNLOAD is left, so this is low outside UNLOAD.
  assign out_last    = (row_q == 2'd3);
  assign busy        = (state_q != ST_LOAD) || (beat_q != 3'd0);
  assign err_timeout = err_q;
  assign jobs_done   = jobs_q;

endmodule

// File: tb/tb_systolic_tile_ctrl_30.sv
// Testbench for systolic_tile_ctrl_30: randomized jobs checked against a
// tile-level reference model (matrices, capture-cycle arithmetic, job count).
module tb_systolic_tile_ctrl_30;

  localparam int N        = 16;
  localparam int MIN_WAIT = 3;
  localparam int TIMEOUT  = 64;

  logic          clk_30 = 1'b0;
  logic          reset_30;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic [255:0]  arr_a;
  logic [255:0]  arr_b;
  logic          arr_clr;
  logic [255:0]  arr_z;
  logic          arr_valid;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [1:0]    out_row;
  logic          out_last;
  logic          busy;
  logic          err_timeout;
  logic [7:0]    jobs_done;

  always #5 clk_30 = ~clk_30;

  systolic_tile_ctrl_30 #(
    .N        (N),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_30      (clk_30),
    .reset_30    (reset_30),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .arr_a       (arr_a),
    .arr_b       (arr_b),
    .arr_clr     (arr_clr),
    .arr_z       (arr_z),
    .arr_valid   (arr_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_last    (out_last),
    .busy        (busy),
    .err_timeout (err_timeout),
    .jobs_done   (jobs_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: the tiles of the current job, job count, error flag.
  logic [15:0] m_a [4][4];
  logic [15:0] m_b [4][4];
  logic [15:0] m_z [4][4];
  logic [7:0]  m_jobs;
  logic        m_err;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_30);
    #1;
  endtask

  function automatic logic [255:0] pack(input logic [15:0] m [4][4]);
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[(4*r+c)*16 +: 16] = m[r][c];
    return v;
  endfunction

  function automatic logic [63:0] zrow(input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = m_z[r][c];
    return v;
  endfunction

  // One job: load, clear, run until arr_valid is honoured (from RUN cycle v,
  // v >= MIN_WAIT) or the timeout, then unload. rst_row >= 0 pulses reset
  // when that row is about to be unloaded.
  task automatic job(input bit pat, input int v, input int stall1, input int maxstall,
                     input int rst_row, input bit hold, input bit gaps);
    bit           tmo;
    int           cap;
    int           n;
    logic [255:0] a_exp;
    logic [255:0] b_exp;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pat) begin
          m_a[r][c] = {8'(r), 4'(r), 4'(c)};
          m_b[r][c] = {8'(r + 4), 4'(r), 4'(c)};
        end else begin
          m_a[r][c] = 16'($urandom);
          m_b[r][c] = 16'($urandom);
        end
        m_z[r][c] = 16'($urandom);
      end
    end
    a_exp = pack(m_a);
    b_exp = pack(m_b);
    tmo   = (v > TIMEOUT - 1);
    cap   = tmo ? TIMEOUT - 1 : v;
    arr_z = pack(m_z);

    check("load_ready", in_ready, 1'b1);
    for (int b = 0; b < 8; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          in_valid = 1'b0;
          in_data  = {32'($urandom), 32'($urandom)};
          step();
        end
      end
      for (int c = 0; c < 4; c++)
        in_data[c*16 +: 16] = (b < 4) ? m_a[b][c] : m_b[b-4][c];
      in_valid = 1'b1;
      step();
      if (b == 0) check("busy_after_beat0", busy, 1'b1);
    end
    check("clr_pulse", arr_clr, 1'b1);
    check("clear_not_ready", in_ready, 1'b0);
    check("arr_a_loaded", arr_a, a_exp);
    check("arr_b_loaded", arr_b, b_exp);
    if (pat) begin
      check("arr_a_2_3", arr_a[(4*2+3)*16 +: 16], 16'h0223);
      check("arr_b_1_0", arr_b[(4*1+0)*16 +: 16], 16'h0510);
    end

    // CLEAR cycle: junk on in_valid/arr_valid must be ignored.
    in_valid  = 1'b1;
    in_data   = {32'($urandom), 32'($urandom)};
    arr_valid = hold ? 1'b1 : 1'($urandom);
    step();
    check("clr_one_cycle", arr_clr, 1'b0);

    for (int k = 0; k <= cap; k++) begin
      arr_valid = (k < MIN_WAIT) ? (hold ? 1'b1 : 1'($urandom)) : 1'(k >= v);
      in_valid  = 1'(k < MIN_WAIT);
      in_data   = {32'($urandom), 32'($urandom)};
      step();
      if (k < cap)
        check("run_wait", {out_valid, in_ready, arr_clr, err_timeout}, {3'b000, m_err});
    end
    in_valid  = 1'b0;
    arr_valid = 1'b0;

    if (tmo) begin
      m_err = 1'b1;
      check("tmo_err", err_timeout, 1'b1);
      check("tmo_ready", in_ready, 1'b1);
      check("tmo_no_out", out_valid, 1'b0);
      check("tmo_busy", busy, 1'b0);
      check("tmo_jobs", jobs_done, m_jobs);
      check("tmo_hold_a", arr_a, a_exp);
      check("tmo_hold_b", arr_b, b_exp);
      return;
    end

    // Captured results must not follow later changes on the array bus.
    arr_z = ~arr_z;
    check("cap_valid", out_valid, 1'b1);
    check("cap_row0", out_row, 2'd0);
    check("cap_err", err_timeout, m_err);
    check("run_hold_a", arr_a, a_exp);

    for (int r = 0; r < 4; r++) begin
      if (r == rst_row) begin
        #2 reset_30 = 1'b1;
        #1;
        m_jobs = '0;
        m_err  = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_jobs", jobs_done, m_jobs);
        check("rst_err", err_timeout, m_err);
        check("rst_busy", busy, 1'b0);
        check("rst_arr_a", arr_a, 256'd0);
        check("rst_out_data", out_data, 64'd0);
        #2 reset_30 = 1'b0;
        out_ready = 1'b0;
        step();
        return;
      end
      n = (r == 1 && stall1 >= 0) ? stall1 : int'($urandom_range(0, maxstall));
      out_ready = 1'b0;
      for (int s = 0; s < n; s++) begin
        step();
        check("stall_hold", {out_valid, out_last, out_row, out_data},
              {1'b1, 1'(r == 3), 2'(r), zrow(r)});
      end
      out_ready = 1'b1;
      check("row_out", {out_valid, out_last, out_row, out_data},
            {1'b1, 1'(r == 3), 2'(r), zrow(r)});
      step();
    end
    out_ready = 1'b0;
    m_jobs    = m_jobs + 8'd1;
    check("done_ready", in_ready, 1'b1);
    check("done_no_out", out_valid, 1'b0);
    check("done_jobs", jobs_done, m_jobs);
    check("done_busy", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_30  = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    arr_z     = '0;
    arr_valid = 1'b0;
    out_ready = 1'b0;
    m_jobs    = '0;
    m_err     = 1'b0;
    step();
    step();
    check("reset_ctrl", {in_ready, out_valid, out_last, arr_clr, busy, err_timeout},
          6'b100000);
    check("reset_arr_a", arr_a, 256'd0);
    check("reset_arr_b", arr_b, 256'd0);
    check("reset_out", {out_data, out_row, jobs_done}, 74'd0);
    #2 reset_30 = 1'b0;
    step();

    // Directed tile pattern, arr_valid held from CLEAR, long stall on row 1.
    job(1'b1, MIN_WAIT, 5, 0, -1, 1'b1, 1'b0);
    // arr_valid never asserted: timeout.
    job(1'b0, 1000, -1, 2, -1, 1'b0, 1'b1);
    // Random capture latency, random gaps and backpressure.
    repeat (4) job(1'b0, int'($urandom_range(MIN_WAIT, 20)), -1, 2, -1, 1'b0, 1'b1);
    // Reset in UNLOAD at row 2, then a fresh job.
    job(1'b0, MIN_WAIT + 2, -1, 1, 2, 1'b0, 1'b0);
    job(1'b0, MIN_WAIT, -1, 1, -1, 1'b0, 1'b1);
    // Back-to-back best-case jobs take the counter through the wrap.
    for (int j = 0; j < 255; j++) job(1'b0, MIN_WAIT, -1, 0, -1, 1'b0, 1'b0);
    check("jobs_wrap", jobs_done, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
